// File: rtl/rope_renderer_if.sv
// Pixel/node bus between the VGA timing + rope simulation side (master) and rope_renderer (slave).
interface rope_renderer_if #(
  parameter int unsigned N_NODES = 20,
  parameter int unsigned COORD_W = 10
);
  logic                         video_on;
  logic [COORD_W-1:0]           pix_x;
  logic [COORD_W-1:0]           pix_y;
  logic                         frame_start;
  logic [N_NODES*COORD_W-1:0]   nodes_x;
  logic [N_NODES*COORD_W-1:0]   nodes_y;
  logic                         nodes_valid;
  logic [2:0]                   graph_rgb;
  logic                         hit;
  logic                         snap_stale;

  modport master (
    output video_on, pix_x, pix_y, frame_start, nodes_x, nodes_y, nodes_valid,
    input  graph_rgb, hit, snap_stale
  );

  modport slave (
    input  video_on, pix_x, pix_y, frame_start, nodes_x, nodes_y, nodes_valid,
    output graph_rgb, hit, snap_stale
  );
endinterface

// File: rtl/rope_renderer.sv
// Draws a chain of rope nodes as filled circles via a 3-stage pixel pipeline with per-frame node snapshot.
// Optional head-node highlight colour: define ROPE_RENDERER_HEAD_EN.
module rope_renderer #(
  parameter int unsigned N_NODES    = 20,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned RADIUS     = 5,
  parameter logic [2:0]  NODE_COLOR = 3'b101,
  parameter logic [2:0]  HEAD_COLOR = 3'b110,
  parameter logic [2:0]  BG_COLOR   = 3'b010
) (
  input  logic          clk,
  input  logic          reset,
  rope_renderer_if.slave bus
);

  localparam int unsigned BUS_W = N_NODES * COORD_W;
  localparam int unsigned RAD_W = $clog2(RADIUS + 1);
  localparam int unsigned SUM_W = 2 * RAD_W + 1;
  localparam int unsigned R_SQ  = RADIUS * RADIUS;

  typedef enum logic {EMPTY, LIVE} state_e;

  state_e             state_q, state_d;
  logic               stale_q, stale_d;
  logic               cap_c;
  logic [BUS_W-1:0]   sx_q, sy_q;

  logic               v1_q, live1_q;
  logic [COORD_W-1:0] dx_q [N_NODES];
  logic [COORD_W-1:0] dy_q [N_NODES];
  logic [COORD_W-1:0] dx_d [N_NODES];
  logic [COORD_W-1:0] dy_d [N_NODES];

  logic               v2_q;
  logic [N_NODES-1:0] in_q, in_d;

  logic [2:0]         rgb_q, rgb_d;
  logic               hit_q, hit_d;

  // Magnitude of a signed (COORD_W+1)-bit difference; no modular wrap.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[COORD_W] ? COORD_W'(-d) : COORD_W'(d);
  endfunction

  function automatic logic in_circle(input logic [COORD_W-1:0] dx,
                                     input logic [COORD_W-1:0] dy);
    logic [SUM_W-1:0] ax, ay;
    if (dx > COORD_W'(RADIUS) || dy > COORD_W'(RADIUS)) return 1'b0;
    ax = SUM_W'(dx);
    ay = SUM_W'(dy);
    return (ax * ax + ay * ay) <= SUM_W'(R_SQ);
  endfunction

  // Snapshot FSM: next state and capture strobe.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    cap_c   = 1'b0;
    if (bus.frame_start) begin
      if (bus.nodes_valid) begin
        cap_c   = 1'b1;
        state_d = LIVE;
        stale_d = 1'b0;
      end else begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      stale_q <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      if (cap_c) begin
        sx_q <= bus.nodes_x;
        sy_q <= bus.nodes_y;
      end
    end
  end

  // Stage 1 distances from the shadow; stage 2 circle test, forced low when no snapshot.
  always_comb begin
    for (int i = 0; i < int'(N_NODES); i++) begin
      dx_d[i] = abs_diff(sx_q[i*COORD_W +: COORD_W], bus.pix_x);
      dy_d[i] = abs_diff(sy_q[i*COORD_W +: COORD_W], bus.pix_y);
      in_d[i] = live1_q & in_circle(dx_q[i], dy_q[i]);
    end
  end

`ifdef ROPE_RENDERER_HEAD_EN
  logic head_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) head_q <= 1'b0;
    else        head_q <= in_d[N_NODES-1];
  end

  always_comb begin
    hit_d = |in_q;
    rgb_d = BG_COLOR;
    if (!v2_q)       rgb_d = 3'b000;
    else if (head_q) rgb_d = HEAD_COLOR;
    else if (hit_d)  rgb_d = NODE_COLOR;
  end
`else
  always_comb begin
    hit_d = |in_q;
    rgb_d = BG_COLOR;
    if (!v2_q)      rgb_d = 3'b000;
    else if (hit_d) rgb_d = NODE_COLOR;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      live1_q <= 1'b0;
      for (int i = 0; i < int'(N_NODES); i++) begin
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
      v2_q    <= 1'b0;
      in_q    <= '0;
      rgb_q   <= 3'b000;
      hit_q   <= 1'b0;
    end else begin
      v1_q    <= bus.video_on;
      live1_q <= (state_q == LIVE);
      for (int i = 0; i < int'(N_NODES); i++) begin
        dx_q[i] <= dx_d[i];
        dy_q[i] <= dy_d[i];
      end
      v2_q    <= v1_q;
      in_q    <= in_d;
      rgb_q   <= rgb_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.graph_rgb  = rgb_q;
  assign bus.hit        = hit_q;
  assign bus.snap_stale = stale_q;

endmodule

// File: tb/tb_rope_renderer.sv
// Directed bench for rope_renderer: snapshot FSM, circle test, latency, blanking, head colour, async reset.
module tb_rope_renderer;
  localparam int unsigned N = 20;
  localparam int unsigned W = 10;

`ifdef ROPE_RENDERER_HEAD_EN
  localparam logic [2:0] HEAD_EXP = 3'b110;
`else
  localparam logic [2:0] HEAD_EXP = 3'b101;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rope_renderer_if #(.N_NODES(N), .COORD_W(W)) bus ();

  rope_renderer #(.N_NODES(N), .COORD_W(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_node(input int i, input int x, input int y);
    bus.nodes_x[i*W +: W] = W'(x);
    bus.nodes_y[i*W +: W] = W'(y);
  endtask

  task automatic park_nodes();
    for (int i = 0; i < int'(N); i++) set_node(i, 600, 400);
  endtask

  task automatic capture(input logic valid);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.nodes_valid = valid;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.nodes_valid = 1'b1;
  endtask

  // Present one pixel and wait until its result is at the outputs.
  task automatic pixel(input int x, input int y, input logic v);
    @(negedge clk);
    bus.pix_x    = W'(x);
    bus.pix_y    = W'(y);
    bus.video_on = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.video_on = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
    bus.frame_start = 1'b0; bus.nodes_valid = 1'b1;
    park_nodes();
    repeat (2) @(negedge clk);
    vectors++; if (bus.graph_rgb !== 3'b000) begin miscompares++; $display("FAIL reset_rgb got %b exp 000", bus.graph_rgb); end
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b exp 0", bus.hit); end
    vectors++; if (bus.snap_stale !== 1'b0) begin miscompares++; $display("FAIL reset_stale got %b exp 0", bus.snap_stale); end
    rst_n = 1'b1;
  endtask

  task automatic test_empty();
    set_node(0, 0, 0);
    pixel(0, 0, 1'b1);
    vectors++; if (bus.graph_rgb !== 3'b010) begin miscompares++; $display("FAIL empty_rgb got %b exp 010", bus.graph_rgb); end
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL empty_hit got %b exp 0", bus.hit); end
  endtask

  task automatic test_capture();
    park_nodes();
    set_node(0, 100, 100);
    capture(1'b1);
    vectors++; if (bus.snap_stale !== 1'b0) begin miscompares++; $display("FAIL cap_stale got %b exp 0", bus.snap_stale); end
    pixel(103, 104, 1'b1);
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL cap_in_hit got %b exp 1", bus.hit); end
    vectors++; if (bus.graph_rgb !== 3'b101) begin miscompares++; $display("FAIL cap_in_rgb got %b exp 101", bus.graph_rgb); end
    pixel(104, 104, 1'b1);
    vectors++; if (bus.graph_rgb !== 3'b010) begin miscompares++; $display("FAIL cap_out_rgb got %b exp 010", bus.graph_rgb); end
    pixel(105, 100, 1'b1);
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL cap_edge_hit got %b exp 1", bus.hit); end
    pixel(100, 106, 1'b1);
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL cap_bbox_hit got %b exp 0", bus.hit); end
    pixel(97, 96, 1'b1);
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL cap_neg_hit got %b exp 1", bus.hit); end
  endtask

  task automatic test_stale();
    set_node(0, 50, 50);
    capture(1'b1);
    set_node(0, 200, 200);
    capture(1'b0);
    vectors++; if (bus.snap_stale !== 1'b1) begin miscompares++; $display("FAIL stale_flag got %b exp 1", bus.snap_stale); end
    pixel(50, 50, 1'b1);
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL stale_old_hit got %b exp 1", bus.hit); end
    pixel(200, 200, 1'b1);
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL stale_new_hit got %b exp 0", bus.hit); end
  endtask

  task automatic test_no_wrap();
    set_node(0, 0, 0);
    capture(1'b1);
    vectors++; if (bus.snap_stale !== 1'b0) begin miscompares++; $display("FAIL wrap_stale_clr got %b exp 0", bus.snap_stale); end
    pixel(1023, 0, 1'b1);
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL wrap_far_hit got %b exp 0", bus.hit); end
    pixel(0, 5, 1'b1);
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL wrap_ctrl_hit got %b exp 1", bus.hit); end
  endtask

  task automatic test_blanking();
    logic [15:0] pat;
    logic [2:0]  exp_rgb;
    pixel(0, 0, 1'b0);
    vectors++; if (bus.graph_rgb !== 3'b000) begin miscompares++; $display("FAIL blank_rgb got %b exp 000", bus.graph_rgb); end
    vectors++; if (bus.hit !== 1'b1) begin miscompares++; $display("FAIL blank_hit got %b exp 1", bus.hit); end
    pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        exp_rgb = pat[i-3] ? 3'b101 : 3'b000;
        vectors++;
        if (bus.graph_rgb !== exp_rgb) begin
          miscompares++; $display("FAIL latency_%0d got %b exp %b", i, bus.graph_rgb, exp_rgb);
        end
      end
      bus.video_on = pat[i];
    end
  endtask

  task automatic test_back_to_back();
    int  xi;
    logic exp_hit;
    set_node(0, 100, 100);
    capture(1'b1);
    bus.video_on = 1'b1;
    bus.pix_y    = W'(100);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        xi = 94 + i - 3;
        exp_hit = (xi >= 95) && (xi <= 105);
        vectors++;
        if (bus.hit !== exp_hit) begin
          miscompares++; $display("FAIL stream_x%0d got %b exp %b", xi, bus.hit, exp_hit);
        end
      end
      if (i < 15) bus.pix_x = W'(94 + i);
      if (i == 7) set_node(0, 0, 0);
    end
  endtask

  task automatic test_head();
    park_nodes();
    set_node(0, 300, 200);
    set_node(int'(N) - 1, 300, 200);
    capture(1'b1);
    pixel(300, 200, 1'b1);
    vectors++; if (bus.graph_rgb !== HEAD_EXP) begin miscompares++; $display("FAIL head_rgb got %b exp %b", bus.graph_rgb, HEAD_EXP); end
    set_node(int'(N) - 1, 400, 200);
    capture(1'b1);
    pixel(400, 203, 1'b1);
    vectors++; if (bus.graph_rgb !== HEAD_EXP) begin miscompares++; $display("FAIL head_only_rgb got %b exp %b", bus.graph_rgb, HEAD_EXP); end
    pixel(300, 200, 1'b1);
    vectors++; if (bus.graph_rgb !== 3'b101) begin miscompares++; $display("FAIL body_rgb got %b exp 101", bus.graph_rgb); end
  endtask

  task automatic test_reset_mid();
    capture(1'b0);
    pixel(300, 200, 1'b1);
    vectors++; if (bus.hit !== 1'b1 || bus.snap_stale !== 1'b1) begin
      miscompares++; $display("FAIL premid_state got hit=%b stale=%b exp 1 1", bus.hit, bus.snap_stale);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.graph_rgb !== 3'b000) begin miscompares++; $display("FAIL midrst_rgb got %b exp 000", bus.graph_rgb); end
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL midrst_hit got %b exp 0", bus.hit); end
    vectors++; if (bus.snap_stale !== 1'b0) begin miscompares++; $display("FAIL midrst_stale got %b exp 0", bus.snap_stale); end
    @(negedge clk);
    rst_n = 1'b1;
    pixel(300, 200, 1'b1);
    vectors++; if (bus.graph_rgb !== 3'b010) begin miscompares++; $display("FAIL postrst_rgb got %b exp 010", bus.graph_rgb); end
    vectors++; if (bus.hit !== 1'b0) begin miscompares++; $display("FAIL postrst_hit got %b exp 0", bus.hit); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_empty();
    test_capture();
    test_stale();
    test_no_wrap();
    test_blanking();
    test_back_to_back();
    test_head();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rope_renderer.md
# rope_renderer

Pixel-stream renderer that draws a parametrised chain of rope nodes as filled circles over a background colour for the VGA output path. It sits between the rope simulation (packed node-coordinate buses) and the VGA sync/colour output. It latches a tear-free snapshot of all node positions once per frame and evaluates every pixel through a fixed 3-stage pipeline. The optional head-node highlight is described under Configuration.

## Interface
Parameters:
- `N_NODES`, 20: number of rope nodes (1–64).
- `COORD_W`, 10: coordinate width in bits.
- `RADIUS`, 5: circle radius in pixels (1–15).
- `NODE_COLOR`, 3'b101: colour of pixels inside any node circle.
- `HEAD_COLOR`, 3'b110: colour of the head node (index `N_NODES-1`) when the head highlight is compiled in.
- `BG_COLOR`, 3'b010: colour of visible pixels outside all circles.

Ports:
- `clk` in 1: single system clock, one pixel per cycle.
- `reset` in 1: asynchronous, active-low reset.
- `video_on` in 1: the current pixel is in the visible area.
- `pix_x`, `pix_y` in `COORD_W`: current pixel coordinates.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `nodes_x`, `nodes_y` in `N_NODES*COORD_W`: packed node centres. Node i occupies bits `[i*COORD_W +: COORD_W]`.
- `nodes_valid` in 1: the node buses are stable and may be captured.
- `graph_rgb` out 3: registered pixel colour.
- `hit` out 1: registered; the pixel lies inside at least one circle.
- `snap_stale` out 1: registered; the last `frame_start` found `nodes_valid` low.

## Operation
- Snapshot FSM, two states:
  - EMPTY: the state after reset; no snapshot is held.
  - LIVE: a snapshot is held.
- Snapshot transitions:
  - `frame_start` && `nodes_valid`: copy both buses into the shadow registers, go to LIVE, clear `snap_stale`.
  - `frame_start` && !`nodes_valid`: keep the current state and shadow, set `snap_stale`.
  - Otherwise: hold.
- The shadow registers never change outside a `frame_start` cycle. Mid-frame changes on the node buses are invisible until the next frame.
- Stage 1: register `video_on` and the pixel coordinates. For each node, compute `dx` = |node_x − pix_x| and `dy` = |node_y − pix_y| as unsigned magnitudes of a signed (`COORD_W`+1)-bit difference. There is no modular wrap: the node at x=0 and pixel x=1023 give dx=1023.
- Stage 2, per node:
  - Bounding-box reject if `dx` > `RADIUS` or `dy` > `RADIUS`.
  - Otherwise compute in_i = dx² + dy² ≤ `RADIUS`². The sum is 2·(bits of `RADIUS`)+1 wide, so it cannot overflow.
  - Register the per-node `in` vector.
- Stage 3: OR-reduce the `in` vector into `hit` and select the colour:
  - !`video_on`: 3'b000.
  - else `hit`: `NODE_COLOR` (or `HEAD_COLOR`, see Configuration).
  - else: `BG_COLOR`.
- In EMPTY, the `in` vector is forced to 0, so only background or black is produced.
- Overlapping circles use the same colour. Only a head hit changes colour.

## Timing
- Latency: exactly 3 clocks from `pix_x`/`pix_y`/`video_on` to `graph_rgb`/`hit`. The caller delays hsync/vsync by 3 to match.
- Throughput: one pixel per clock, with no stalls.
- Snapshot capture takes effect on the `clk` edge where `frame_start`=1. The pixel presented on the following cycle uses the new shadow.
- A `frame_start` coinciding with a visible pixel is legal. Pixels already in the pipeline finish using the values they sampled; the shadow is read in stage 1.
- Reset (asserted low, asynchronous):
  - `graph_rgb`=0, `hit`=0, `snap_stale`=0.
  - All pipeline registers are cleared and the FSM enters EMPTY.
  - Shadow coordinates are cleared to 0.
  - Reset mid-frame discards in-flight pixels. The first valid output appears 3 clocks after release.
- Reset release is assumed synchronous to `clk` by the reset synchroniser upstream.

## Configuration
- `ROPE_RENDERER_HEAD_EN` defined:
  - Stage 2 additionally registers head_in = in[`N_NODES-1`].
  - Stage 3 outputs `HEAD_COLOR` when head_in is 1. The head takes priority over other overlapping nodes.
- Undefined: all hits produce `NODE_COLOR`, and the head_in logic is absent.

## Test plan
- Capture and render:
  - Stimulus: reset, then `frame_start` with `nodes_valid`=1 and node 0 at (100,100).
  - Pixel (103,104) (9+16=25 ≤ 25): `hit`=1, `graph_rgb`=3'b101, three clocks later.
  - Pixel (104,104): `graph_rgb`=3'b010.
- EMPTY state: after reset with no `frame_start`, pixel (0,0) with `video_on`=1 → `graph_rgb`=3'b010, `hit`=0.
- Stale snapshot:
  - Stimulus: capture node 0 at (50,50); change the bus to (200,200); pulse `frame_start` with `nodes_valid`=0.
  - Response: `snap_stale`=1; pixel (50,50) still hits; pixel (200,200) does not.
- No wrap:
  - Stimulus: node at (0,0), pixel (1023,0).
  - Response: `hit`=0.
  - Control: pixel (0,5) → `hit`=1.
- Blanking and latency:
  - Stimulus: a `video_on`=0 pixel inside a circle.
  - Response: `graph_rgb`=3'b000, `hit`=1.
  - Latency check: toggle `video_on` each cycle and confirm the output toggles exactly 3 clocks later.
- Head highlight and reset:
  - Stimulus (with `ROPE_RENDERER_HEAD_EN`): nodes 0 and 19 both at (300,200); pixel (300,200).
  - Response: `graph_rgb`=3'b110.
  - Reset: assert reset mid-line → all outputs are 0 immediately, without waiting for a clock.
